// File: rtl/io_port_ctrl_pkg.sv
// Shared definitions for the memory-mapped I/O port controller:
// word addresses (addr[7:2]), CTRL register bit positions, the key
// debounce state encoding and the default debounce length.
package io_port_pkg;

    // Word addresses, i.e. byte address >> 2
    localparam logic [5:0] ADDR_IN0  = 6'h20;  // 0x80
    localparam logic [5:0] ADDR_IN1  = 6'h21;  // 0x84
    localparam logic [5:0] ADDR_OUT0 = 6'h30;  // 0xC0
    localparam logic [5:0] ADDR_OUT1 = 6'h31;  // 0xC4
    localparam logic [5:0] ADDR_CTRL = 6'h32;  // 0xC8

    // CTRL register bit positions
    localparam int CTRL_PLUS_BIT = 0;
    localparam int CTRL_CHG_BIT  = 1;
    localparam int CTRL_IE_BIT   = 2;

    // 10 ms at 50 MHz
    localparam int DEB_CYCLES_DEF = 500000;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REL_WAIT
    } deb_state_t;

endpackage

// File: rtl/io_port_ctrl_key_debounce.sv
// Mode-key debouncer: two-flop synchroniser on the raw active-low key,
// then a press/release FSM. A press or release is accepted only after
// DEB_CYCLES consecutive stable samples; an accepted press emits a
// single-cycle toggle pulse.
module key_debounce
    import io_port_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int DEB_W      = 19
) (
    input  logic clk,
    input  logic resetn,
    input  logic key_n,
    output logic toggle
);

    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             key_s1;
    logic             key_s2;
    deb_state_t       state;
    logic [DEB_W-1:0] cnt;

    // Bring the asynchronous key into the clock domain
    always_ff @(posedge clk) begin
        if (!resetn) begin
            key_s1 <= 1'b0;
            key_s2 <= 1'b0;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
        end
    end

    // Press/release qualification; toggle is a registered 1-cycle pulse
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            toggle <= 1'b0;
        end else begin
            toggle <= 1'b0;
            case (state)
                IDLE: begin
                    if (!key_s2) begin
                        cnt   <= '0;
                        state <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (key_s2) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state  <= HELD;
                        toggle <= 1'b1;
                    end else begin
                        cnt <= cnt + DEB_W'(1);
                    end
                end
                HELD: begin
                    if (key_s2) begin
                        cnt   <= '0;
                        state <= REL_WAIT;
                    end
                end
                REL_WAIT: begin
                    if (!key_s2) begin
                        state <= HELD;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + DEB_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/io_port_ctrl.sv
// Memory-mapped I/O controller between the CPU data bus and the board
// switch / seven-segment logic. Switch inputs are synchronised and
// change-detected, two output port registers feed the display, and the
// debounced mode key toggles ctrl_plus. Single-cycle req/ack access.
// Optional build macro IO_IRQ_EN adds the CTRL.ie bit and the irq output.
module io_port_ctrl
    import io_port_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int DEB_W      = 19
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  sw0,
    input  logic [7:0]  sw1,
    input  logic        key_n,
    input  logic        req,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic [31:0] out_port0,
    output logic [31:0] out_port1,
    output logic        ctrl_plus,
    output logic        irq
);

    logic [7:0]  sw0_s1, sw0_s2, sw1_s1, sw1_s2;
    logic [7:0]  snap0, snap1;
    logic        chg;
    logic        ie;
    logic        toggle;
    logic [31:0] rd_mux;
    logic [5:0]  sel;
    logic        wr, rd;
    logic        unused_addr_bits;

    assign sel = addr[7:2];
    assign wr  = req & we;
    assign rd  = req & ~we;
    assign unused_addr_bits = ^addr[1:0];

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) u_deb (
        .clk    (clk),
        .resetn (resetn),
        .key_n  (key_n),
        .toggle (toggle)
    );

    // Two-flop synchronisers for both switch groups
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sw0_s1 <= '0;
            sw0_s2 <= '0;
            sw1_s1 <= '0;
            sw1_s2 <= '0;
        end else begin
            sw0_s1 <= sw0;
            sw0_s2 <= sw0_s1;
            sw1_s1 <= sw1;
            sw1_s2 <= sw1_s1;
        end
    end

    // Change detect against snapshot; a new change beats a CTRL read-clear
    always_ff @(posedge clk) begin
        if (!resetn) begin
            snap0 <= '0;
            snap1 <= '0;
            chg   <= 1'b0;
        end else begin
            snap0 <= sw0_s2;
            snap1 <= sw1_s2;
            if ((sw0_s2 != snap0) || (sw1_s2 != snap1)) begin
                chg <= 1'b1;
            end else if (rd && (sel == ADDR_CTRL)) begin
                chg <= 1'b0;
            end
        end
    end

    // Output ports and display select; a CPU write to CTRL overrides the key toggle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_port0 <= '0;
            out_port1 <= '0;
            ctrl_plus <= 1'b0;
        end else begin
            if (wr && (sel == ADDR_OUT0)) out_port0 <= wdata;
            if (wr && (sel == ADDR_OUT1)) out_port1 <= wdata;
            if (wr && (sel == ADDR_CTRL)) begin
                ctrl_plus <= wdata[CTRL_PLUS_BIT];
            end else if (toggle) begin
                ctrl_plus <= ~ctrl_plus;
            end
        end
    end

`ifdef IO_IRQ_EN
    // Interrupt enable bit and registered interrupt
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ie  <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (wr && (sel == ADDR_CTRL)) ie <= wdata[CTRL_IE_BIT];
            irq <= ie & chg;
        end
    end
`else
    assign ie  = 1'b0;
    assign irq = 1'b0;
`endif

    // Read data selection by word address; unmapped words read 0
    always_comb begin
        rd_mux = '0;
        case (sel)
            ADDR_IN0:  rd_mux = {24'b0, sw0_s2};
            ADDR_IN1:  rd_mux = {24'b0, sw1_s2};
            ADDR_OUT0: rd_mux = out_port0;
            ADDR_OUT1: rd_mux = out_port1;
            ADDR_CTRL: begin
                rd_mux[CTRL_PLUS_BIT] = ctrl_plus;
                rd_mux[CTRL_CHG_BIT]  = chg;
                rd_mux[CTRL_IE_BIT]   = ie;
            end
            default: rd_mux = '0;
        endcase
    end

    // One-cycle acknowledge with registered read data
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ack   <= 1'b0;
            rdata <= '0;
        end else begin
            ack   <= req;
            rdata <= rd ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl with a short debounce (DEB_CYCLES=8).
// Inputs change on the falling edge; outputs are sampled on the falling
// edge. Compile with +define+IO_IRQ_EN to cover the interrupt build.
module tb_io_port_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  sw0, sw1;
    logic        key_n;
    logic        req, we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic [31:0] out_port0, out_port1;
    logic        ctrl_plus;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    io_port_ctrl #(
        .DEB_CYCLES (8),
        .DEB_W      (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .sw0       (sw0),
        .sw1       (sw1),
        .key_n     (key_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ack       (ack),
        .out_port0 (out_port0),
        .out_port1 (out_port1),
        .ctrl_plus (ctrl_plus),
        .irq       (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bus access; returns at the falling edge inside the ack cycle
    task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0; addr = 8'h00; wdata = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; sw0 = 8'h00; sw1 = 8'h00; key_n = 1'b1;
        req = 1'b0; we = 1'b0; addr = 8'h00; wdata = 32'h0;
        cycles(2);
        resetn = 1'b1;
        check("rst_ack",   {31'b0, ack}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_out1",  out_port1, 32'h0);
        check("rst_plus",  {31'b0, ctrl_plus}, 32'h0);
        check("rst_irq",   {31'b0, irq}, 32'h0);
        cycles(4);

        // Reset with a pending access clears everything
        bus(1'b1, 8'hC0, 32'h0000_1234);
        check("out0_pre", out_port0, 32'h0000_1234);
        req = 1'b1; we = 1'b0; addr = 8'hC0; resetn = 1'b0;
        cycles(1);
        check("rst_mid_ack", {31'b0, ack}, 32'h0);
        cycles(1);
        req = 1'b0; addr = 8'h00; resetn = 1'b1;
        check("rst_out0", out_port0, 32'h0);
        check("rst_rdata2", rdata, 32'h0);
        cycles(4);

        // Write / read OUT1
        bus(1'b1, 8'hC4, 32'hFFFF_F005);
        check("wr_ack",  {31'b0, ack}, 32'h1);
        check("wr_out1", out_port1, 32'hFFFF_F005);
        cycles(1);
        check("ack_drop", {31'b0, ack}, 32'h0);
        bus(1'b0, 8'hC4, 32'h0);
        check("rd_ack",  {31'b0, ack}, 32'h1);
        check("rd_out1", rdata, 32'hFFFF_F005);
        cycles(1);
        check("rdata_idle", rdata, 32'h0);
        bus(1'b0, 8'h90, 32'h0);
        check("unmap_ack", {31'b0, ack}, 32'h1);
        check("unmap_rd",  rdata, 32'h0);

        // Back-to-back: write OUT0 via an address with low bits set, then read it
        req = 1'b1; we = 1'b1; addr = 8'hC3; wdata = 32'hA5A5_0001;
        cycles(1);
        check("b2b_wr_out0", out_port0, 32'hA5A5_0001);
        we = 1'b0; addr = 8'hC0;
        cycles(1);
        check("b2b_rd_ack", {31'b0, ack}, 32'h1);
        check("b2b_rd",     rdata, 32'hA5A5_0001);
        req = 1'b0; addr = 8'h00;
        cycles(1);
        check("b2b_end", {31'b0, ack}, 32'h0);

        // Switch change detection
        sw0 = 8'h3A;
        cycles(3);
        bus(1'b0, 8'hC8, 32'h0);
        check("chg_set", rdata, 32'h2);
        bus(1'b0, 8'hC8, 32'h0);
        check("chg_clr", rdata, 32'h0);
        bus(1'b0, 8'h80, 32'h0);
        check("in0_rd", rdata, 32'h0000_003A);
        // Read-clear at the same edge a new change is detected: set wins
        sw1 = 8'h55;
        cycles(2);
        bus(1'b0, 8'hC8, 32'h0);
        check("chg_race_rd", rdata, 32'h0);
        bus(1'b0, 8'hC8, 32'h0);
        check("chg_race_set", rdata, 32'h2);
        bus(1'b1, 8'h84, 32'h0000_FFFF);
        bus(1'b0, 8'h84, 32'h0);
        check("in1_ro", rdata, 32'h0000_0055);
        bus(1'b0, 8'hC8, 32'h0);
        check("chg_idle", rdata, 32'h0);

        // Debounce: bouncing press, then clean hold
        for (int i = 0; i < 4; i++) begin
            key_n = 1'b0; cycles(3);
            key_n = 1'b1; cycles(3);
        end
        check("bounce_no_tog", {31'b0, ctrl_plus}, 32'h0);
        key_n = 1'b0;
        cycles(12);
        check("press_tog", {31'b0, ctrl_plus}, 32'h1);
        cycles(10);
        check("held_once", {31'b0, ctrl_plus}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            key_n = 1'b1; cycles(3);
            key_n = 1'b0; cycles(3);
        end
        key_n = 1'b1;
        cycles(15);
        check("release_keep", {31'b0, ctrl_plus}, 32'h1);
        key_n = 1'b0;
        cycles(12);
        check("press2_tog", {31'b0, ctrl_plus}, 32'h0);
        key_n = 1'b1;
        cycles(15);

        // Collision: CPU write to CTRL lands on the toggle pulse
        bus(1'b1, 8'hC8, 32'h1);
        check("ctrl_wr1", {31'b0, ctrl_plus}, 32'h1);
        key_n = 1'b0;
        cycles(11);
        bus(1'b1, 8'hC8, 32'h1);
        check("coll_keep1", {31'b0, ctrl_plus}, 32'h1);
        cycles(3);
        check("coll_keep1_late", {31'b0, ctrl_plus}, 32'h1);
        key_n = 1'b1;
        cycles(15);
        bus(1'b1, 8'hC8, 32'h0);
        check("ctrl_wr0", {31'b0, ctrl_plus}, 32'h0);
        key_n = 1'b0;
        cycles(11);
        bus(1'b1, 8'hC8, 32'h1);
        check("coll_set1", {31'b0, ctrl_plus}, 32'h1);
        cycles(3);
        check("coll_set1_late", {31'b0, ctrl_plus}, 32'h1);
        key_n = 1'b1;
        cycles(15);

        // Interrupt enable / irq
        bus(1'b1, 8'hC8, 32'h5);
        bus(1'b0, 8'hC8, 32'h0);
`ifdef IO_IRQ_EN
        check("ie_rd", rdata, 32'h5);
        check("irq_idle", {31'b0, irq}, 32'h0);
        sw1 = 8'hA0;
        cycles(4);
        check("irq_set", {31'b0, irq}, 32'h1);
        bus(1'b0, 8'hC8, 32'h0);
        check("irq_ctrl_rd", rdata, 32'h7);
        check("irq_hold", {31'b0, irq}, 32'h1);
        cycles(1);
        check("irq_fall", {31'b0, irq}, 32'h0);
`else
        check("ie_rd_off", rdata, 32'h1);
        sw1 = 8'hA0;
        cycles(4);
        check("irq_off", {31'b0, irq}, 32'h0);
        bus(1'b0, 8'hC8, 32'h0);
        check("ctrl_rd_off", rdata, 32'h3);
        check("irq_off2", {31'b0, irq}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_port_ctrl.md
Name: io_port_ctrl

Overview:
Memory-mapped I/O controller between the pipelined CPU's data-memory bus and the board's switch and seven-segment port logic.
- Synchronises and change-detects the two 8-bit switch input ports.
- Holds the two 32-bit output port registers that feed the display path.
- Debounces the mode key and produces the display-select (ctrl_plus) level.
- Serves CPU reads and writes through a one-cycle req/ack handshake.

Parameters:
DEB_CYCLES, 500000, number of consecutive stable key samples needed to accept a press or a release (10 ms at 50 MHz).
DEB_W, 19, width of the debounce counter; must satisfy 2^DEB_W > DEB_CYCLES.

Ports:
clk  in  1  system clock
resetn  in  1  reset, synchronous, active-low
sw0  in  8  raw switch group 0, {in0_0,in0_1}; asynchronous
sw1  in  8  raw switch group 1, {in1_0,in1_1}; asynchronous
key_n  in  1  raw mode key, active-low, bouncing
req  in  1  CPU bus access request
we  in  1  1 = write, 0 = read; valid with req
addr  in  8  byte address (low 8 bits of the I/O space)
wdata  in  32  write data
rdata  out  32  read data, valid while ack=1
ack  out  1  access complete
out_port0  out  32  output port 0 register
out_port1  out  32  output port 1 register
ctrl_plus  out  1  display select: 0 = show port0, 1 = show signed port1
irq  out  1  input-change interrupt (only with IO_IRQ_EN; otherwise constant 0)

Behaviour:
- Reset (resetn=0 at a clk edge):
  - rdata=0, ack=0, out_port0=0, out_port1=0, ctrl_plus=0, irq=0.
  - Sync flops and snapshots cleared; debounce FSM to IDLE, counter 0; change flag 0.
  - Reset mid-access: the pending ack is dropped and the CPU retries.
- Input sync: sw0/sw1 each pass through 2 flops. in0/in1 are the synchronised values, zero-extended to 32 bits on read.
- Change detect: each cycle the synced value is compared with a registered snapshot. On mismatch, set chg=1 and update the snapshot. Latency from switch edge to chg=1 is 3 cycles.
- Address map (addr[7:2]; addr[1:0] ignored):
  - 0x80: IN0, read-only.
  - 0x84: IN1, read-only.
  - 0xC0: OUT0, read/write.
  - 0xC4: OUT1, read/write.
  - 0xC8: CTRL = {29'b0, ie, chg, ctrl_plus}. Bit0 is read/write. Bit1 is clear-on-read. Bit2 (ie) is read/write only with IO_IRQ_EN, otherwise reads 0.
  - Any other address: reads 0; writes are ignored; ack is still given.
- Handshake:
  - req sampled at edge N gives ack=1 for exactly one cycle after edge N, with rdata registered alongside.
  - Writes take effect at edge N, so out_port* updates in the same cycle that ack rises.
  - req held high for consecutive cycles is treated as back-to-back accesses, one per cycle. No wait states, no overlap.
  - With ack=0, rdata=0.
- CTRL read clears chg at edge N. If a new input change is detected at the same edge, the set wins and chg stays 1.
- Debounce FSM on the synchronised key_n (2 flops):
  - IDLE: wait for key=0; then counter←0 and go to PRESS_WAIT.
  - PRESS_WAIT: key=0 increments the counter; key=1 returns to IDLE. When counter reaches DEB_CYCLES-1, go to HELD and emit a 1-cycle toggle pulse.
  - HELD: wait for key=1; then counter←0 and go to REL_WAIT.
  - REL_WAIT: key=1 increments the counter; key=0 returns to HELD. When counter reaches DEB_CYCLES-1, go to IDLE.
- ctrl_plus toggles on the toggle pulse.
- A CPU write to CTRL in the same cycle as a toggle pulse: the CPU write wins and the toggle is discarded.

Optional Feature:
Macro IO_IRQ_EN.
- Defined: CTRL bit2 "ie" is implemented (reset 0). irq is registered and equals ie & chg, one cycle after either changes.
- Undefined: no ie storage; irq is constant 0; CTRL bit2 reads 0 and writes to it are ignored.

Decomposition:
- Package io_port_pkg holds the address constants (IN0, IN1, OUT0, OUT1, CTRL), the CTRL bit indices, the debounce state enum {IDLE, PRESS_WAIT, HELD, REL_WAIT} and the default DEB_CYCLES.
- One sub-module, key_debounce (sync + FSM + counter, outputs the toggle pulse), instantiated once.

Test Plan:
- Reset: assert resetn=0 for 2 cycles with out_port0 previously 0x1234 -> all outputs 0; out_port0=0; ctrl_plus=0.
- Write/read: write 0xFFFFF005 to 0xC4, then read 0xC4 -> ack one cycle after each req; out_port1=0xFFFFF005 in the write's ack cycle; rdata=0xFFFFF005.
- Switch change: sw0 goes from 0x00 to 0x3A -> CTRL read ≥3 cycles later returns 0x2; a second CTRL read returns 0x0; IN0 read returns 0x0000003A.
- Debounce (DEB_CYCLES=8):
  - key_n bounces 0/1 every 3 cycles, then is held 0 for 12 cycles -> ctrl_plus goes 0→1 exactly once.
  - Release bounce, then hold 1, then a second clean press -> ctrl_plus returns to 0.
- Collision: CPU writes CTRL=0x1 in the same cycle as the toggle pulse, with ctrl_plus=0 beforehand -> ctrl_plus=1, not toggled back to 0.
- IO_IRQ_EN: write CTRL=0x4, then change sw1 -> irq=1; a CTRL read clears chg and irq falls the next cycle. Build without the macro -> irq stays 0 and CTRL bit2 reads 0.
